// File: rtl/quot_ascii_pkg.sv
// Shared state encoding, ASCII constants and default digit count for quot_ascii_tx.
package quot_ascii_pkg;

    localparam int DIGITS_DEFAULT = 5;

    typedef enum logic [2:0] {IDLE, CONV, SEND, CR, LF} state_e;

    localparam logic [7:0] ASCII_ZERO = 8'h30;
    localparam logic [7:0] ASCII_CR   = 8'h0D;
    localparam logic [7:0] ASCII_LF   = 8'h0A;

endpackage

// File: rtl/quot_ascii_tx_if.sv
// Word-in / byte-out handshake bundle; slave is the converter, master the environment.
interface quot_ascii_tx_if #(
    parameter int N = 16
);
    logic [N-1:0] in_data;
    logic         in_valid;
    logic         in_ready;
    logic [7:0]   tx_data;
    logic         tx_valid;
    logic         tx_ready;
    logic         done;

    modport master (
        output in_data, in_valid, tx_ready,
        input  in_ready, tx_data, tx_valid, done
    );

    modport slave (
        input  in_data, in_valid, tx_ready,
        output in_ready, tx_data, tx_valid, done
    );
endinterface

// File: rtl/quot_ascii_tx_bin2bcd_seq.sv
// Sequential double-dabble: after i_start, N shift-add-3 steps run one per cycle.
module bin2bcd_seq #(
    parameter int N      = 16,
    parameter int DIGITS = 5
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                i_start,
    input  logic [N-1:0]        i_bin,
    output logic                o_busy,
    output logic                o_last,
    output logic [4*DIGITS-1:0] o_bcd
);
    localparam int CW = $clog2(N + 1);

    logic [N-1:0]        r_bin;
    logic [4*DIGITS-1:0] r_bcd;
    logic [CW-1:0]       r_cnt;
    logic [4*DIGITS-1:0] w_adj;

    always_comb begin
        w_adj = r_bcd;
        for (int d = 0; d < DIGITS; d++) begin
            if (r_bcd[4*d +: 4] >= 4'd5)
                w_adj[4*d +: 4] = r_bcd[4*d +: 4] + 4'd3;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_bin <= '0;
            r_bcd <= '0;
            r_cnt <= '0;
        end else if (i_start) begin
            r_bin <= i_bin;
            r_bcd <= '0;
            r_cnt <= CW'(N);
        end else if (o_busy) begin
            r_bcd <= (w_adj << 1) | {{(4*DIGITS-1){1'b0}}, r_bin[N-1]};
            r_bin <= r_bin << 1;
            r_cnt <= r_cnt - 1'b1;
        end
    end

    assign o_busy = (r_cnt != '0);
    assign o_last = (r_cnt == CW'(1));
    assign o_bcd  = r_bcd;
endmodule

// File: rtl/quot_ascii_tx.sv
// Quotient-to-ASCII transmitter: binary word in, decimal digits then CR LF out.
// Define QUOT_ZERO_SUPPRESS_EN to skip leading zero digits (value 0 still prints "0").
module quot_ascii_tx
    import quot_ascii_pkg::*;
#(
    parameter int N      = 16,
    parameter int DIGITS = DIGITS_DEFAULT
) (
    input  logic           clk,
    input  logic           rst,
    quot_ascii_tx_if.slave bus
);
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    localparam logic [2:0] ST_IDLE = 3'(IDLE);
    localparam logic [2:0] ST_CONV = 3'(CONV);
    localparam logic [2:0] ST_SEND = 3'(SEND);
    localparam logic [2:0] ST_CR   = 3'(CR);
    localparam logic [2:0] ST_LF   = 3'(LF);

    logic [2:0]          r_state;
    logic                r_in_ready;
    logic                r_done;
    logic [IW-1:0]       r_idx;
    logic [IW-1:0]       w_idx;
    logic [3:0]          w_nib;
    logic [7:0]          w_tx_data;
    logic [4*DIGITS-1:0] w_bcd;
    logic                w_accept;
    logic                w_busy;
    logic                w_last;

    assign w_accept = bus.in_valid & r_in_ready;

    bin2bcd_seq #(.N(N), .DIGITS(DIGITS)) u_conv (
        .clk     (clk),
        .rst     (rst),
        .i_start (w_accept),
        .i_bin   (bus.in_data),
        .o_busy  (w_busy),
        .o_last  (w_last),
        .o_bcd   (w_bcd)
    );

`ifdef QUOT_ZERO_SUPPRESS_EN
    // Clamp the digit index to the top nonzero digit; only the first SEND cycle is affected.
    logic [IW-1:0] w_hi;
    always_comb begin
        w_hi = '0;
        for (int d = 1; d < DIGITS; d++) begin
            if (w_bcd[4*d +: 4] != 4'h0) w_hi = IW'(d);
        end
        w_idx = (r_idx < w_hi) ? r_idx : w_hi;
    end
`else
    assign w_idx = r_idx;
`endif

    always_comb begin
        w_nib = '0;
        for (int d = 0; d < DIGITS; d++) begin
            if (IW'(d) == w_idx) w_nib = w_bcd[4*d +: 4];
        end
        case (r_state)
            ST_SEND: w_tx_data = ASCII_ZERO + {4'h0, w_nib};
            ST_CR:   w_tx_data = ASCII_CR;
            ST_LF:   w_tx_data = ASCII_LF;
            default: w_tx_data = 8'h00;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_in_ready <= 1'b0;
            r_done     <= 1'b0;
            r_idx      <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    r_in_ready <= ~w_accept;
                    if (w_accept) r_state <= ST_CONV;
                end
                ST_CONV: begin
                    if (w_last || !w_busy) begin
                        r_state <= ST_SEND;
                        r_idx   <= IW'(DIGITS - 1);
                    end
                end
                ST_SEND: begin
                    if (bus.tx_ready) begin
                        if (w_idx == '0) r_state <= ST_CR;
                        else             r_idx   <= w_idx - 1'b1;
                    end
                end
                ST_CR: begin
                    if (bus.tx_ready) r_state <= ST_LF;
                end
                ST_LF: begin
                    if (bus.tx_ready) begin
                        r_state    <= ST_IDLE;
                        r_done     <= 1'b1;
                        r_in_ready <= 1'b1;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign bus.in_ready = r_in_ready;
    assign bus.tx_valid = (r_state == ST_SEND) || (r_state == ST_CR) || (r_state == ST_LF);
    assign bus.tx_data  = w_tx_data;
    assign bus.done     = r_done;
endmodule

// File: tb/tb_quot_ascii_tx.sv
// Directed self-checking bench for quot_ascii_tx (default and QUOT_ZERO_SUPPRESS_EN builds).
module tb_quot_ascii_tx;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    quot_ascii_tx_if #(.N(16)) bus ();

    quot_ascii_tx #(.N(16), .DIGITS(5)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int total = 0;
    int bad   = 0;
    int cycc  = 0;
    always @(posedge clk) cycc <= cycc + 1;

    logic [7:0] cap [16];
    int         stamp [16];
    int         ncap, ndone, done_at;

    task automatic clear_cap();
        ncap = 0; ndone = 0; done_at = -1;
        for (int i = 0; i < 16; i++) begin cap[i] = 8'hFF; stamp[i] = -1; end
    endtask

    // Record every accepted byte and done pulse, one sample per negedge.
    task automatic collect(input int cycles);
        for (int c = 0; c < cycles; c++) begin
            if (bus.tx_valid && bus.tx_ready) begin
                if (ncap < 16) begin cap[ncap] = bus.tx_data; stamp[ncap] = cycc; end
                ncap++;
            end
            if (bus.done) begin ndone++; done_at = cycc; end
            @(negedge clk);
        end
    endtask

    // Offer a word, then count cycles after the accepting cycle until tx_valid.
    task automatic accept(input logic [15:0] v, output int lat);
        int n;
        bus.in_data  = v;
        bus.in_valid = 1'b1;
        n = 0;
        @(negedge clk);
        while (!bus.in_ready && n < 50) begin @(negedge clk); n++; end
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        lat = 1;
        @(negedge clk);
        while (!bus.tx_valid && lat < 40) begin @(negedge clk); lat++; end
    endtask

    task automatic test_reset();
        @(negedge clk);
        total++; if (bus.in_ready !== 1'b0) begin bad++; $display("FAIL rst_in_ready: got %b want 0", bus.in_ready); end
        total++; if (bus.tx_valid !== 1'b0) begin bad++; $display("FAIL rst_tx_valid: got %b want 0", bus.tx_valid); end
        total++; if (bus.tx_data !== 8'h00) begin bad++; $display("FAIL rst_tx_data: got %h want 00", bus.tx_data); end
        total++; if (bus.done !== 1'b0) begin bad++; $display("FAIL rst_done: got %b want 0", bus.done); end
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        total++; if (bus.in_ready !== 1'b0) begin bad++; $display("FAIL rst_drop_cycle_in_ready: got %b want 0", bus.in_ready); end
        @(negedge clk);
        total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL rst_after_in_ready: got %b want 1", bus.in_ready); end
    endtask

    task automatic test_digits();
        logic [15:0] vals [4];
        logic [7:0]  exp [4][7];
        int          elen [4];
        int          lat;
        int          last;
        vals = '{16'd12345, 16'd0, 16'd7, 16'd65535};
        exp[0] = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h0D, 8'h0A}; elen[0] = 7;
`ifdef QUOT_ZERO_SUPPRESS_EN
        exp[1] = '{8'h30, 8'h0D, 8'h0A, 8'h00, 8'h00, 8'h00, 8'h00}; elen[1] = 3;
        exp[2] = '{8'h37, 8'h0D, 8'h0A, 8'h00, 8'h00, 8'h00, 8'h00}; elen[2] = 3;
`else
        exp[1] = '{8'h30, 8'h30, 8'h30, 8'h30, 8'h30, 8'h0D, 8'h0A}; elen[1] = 7;
        exp[2] = '{8'h30, 8'h30, 8'h30, 8'h30, 8'h37, 8'h0D, 8'h0A}; elen[2] = 7;
`endif
        exp[3] = '{8'h36, 8'h35, 8'h35, 8'h33, 8'h35, 8'h0D, 8'h0A}; elen[3] = 7;
        bus.tx_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            accept(vals[i], lat);
            total++; if (lat !== 17) begin bad++; $display("FAIL latency v=%0d: got %0d want 17", vals[i], lat); end
            total++; if (bus.in_ready !== 1'b0) begin bad++; $display("FAIL busy_in_ready v=%0d: got %b want 0", vals[i], bus.in_ready); end
            clear_cap();
            collect(12);
            total++; if (ncap !== elen[i]) begin bad++; $display("FAIL byte_count v=%0d: got %0d want %0d", vals[i], ncap, elen[i]); end
            for (int j = 0; j < elen[i]; j++) begin
                total++;
                if (cap[j] !== exp[i][j]) begin bad++; $display("FAIL byte v=%0d idx=%0d: got %h want %h", vals[i], j, cap[j], exp[i][j]); end
            end
            last = (ncap > 0 && ncap <= 16) ? ncap - 1 : 0;
            total++; if (stamp[last] - stamp[0] !== last) begin bad++; $display("FAIL back_to_back v=%0d: span %0d want %0d", vals[i], stamp[last] - stamp[0], last); end
            total++; if (ndone !== 1 || done_at !== stamp[last] + 1) begin bad++; $display("FAIL done_pulse v=%0d: count %0d at %0d want 1 at %0d", vals[i], ndone, done_at, stamp[last] + 1); end
            total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL idle_in_ready v=%0d: got %b want 1", vals[i], bus.in_ready); end
        end
    endtask

    task automatic test_stall();
        logic [7:0] exp [7];
        int         elen;
        int         lat;
        int         hold_ok;
`ifdef QUOT_ZERO_SUPPRESS_EN
        exp = '{8'h34, 8'h30, 8'h32, 8'h0D, 8'h0A, 8'h00, 8'h00}; elen = 5;
`else
        exp = '{8'h30, 8'h30, 8'h34, 8'h30, 8'h32, 8'h0D, 8'h0A}; elen = 7;
`endif
        bus.tx_ready = 1'b1;
        accept(16'd402, lat);
        total++; if (lat !== 17) begin bad++; $display("FAIL stall_latency: got %0d want 17", lat); end
        total++; if (bus.tx_data !== exp[0]) begin bad++; $display("FAIL stall_first: got %h want %h", bus.tx_data, exp[0]); end
        @(posedge clk); #1;
        bus.tx_ready = 1'b0;
        hold_ok = 1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            if (bus.tx_valid !== 1'b1 || bus.tx_data !== exp[1]) hold_ok = 0;
        end
        total++; if (hold_ok !== 1) begin bad++; $display("FAIL stall_hold: got valid=%b data=%h want 1 %h", bus.tx_valid, bus.tx_data, exp[1]); end
        @(posedge clk); #1;
        bus.tx_ready = 1'b1;
        @(negedge clk);
        clear_cap();
        collect(10);
        total++; if (ncap !== elen - 1) begin bad++; $display("FAIL stall_count: got %0d want %0d", ncap, elen - 1); end
        for (int j = 1; j < elen; j++) begin
            total++;
            if (cap[j-1] !== exp[j]) begin bad++; $display("FAIL stall_byte idx=%0d: got %h want %h", j, cap[j-1], exp[j]); end
        end
        total++; if (ndone !== 1) begin bad++; $display("FAIL stall_done: got %0d want 1", ndone); end
    endtask

    task automatic test_ignore_busy();
        logic [7:0] exp [7];
        int         lat;
        exp = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h0D, 8'h0A};
        bus.tx_ready = 1'b1;
        accept(16'd12345, lat);
        clear_cap();
        bus.in_data  = 16'd999;
        bus.in_valid = 1'b1;
        collect(2);
        bus.in_valid = 1'b0;
        collect(30);
        total++; if (ncap !== 7) begin bad++; $display("FAIL ignore_count: got %0d want 7", ncap); end
        for (int j = 0; j < 7; j++) begin
            total++;
            if (cap[j] !== exp[j]) begin bad++; $display("FAIL ignore_byte idx=%0d: got %h want %h", j, cap[j], exp[j]); end
        end
        total++; if (ndone !== 1) begin bad++; $display("FAIL ignore_done: got %0d want 1", ndone); end
        total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL ignore_in_ready: got %b want 1", bus.in_ready); end
    endtask

    task automatic test_reset_mid();
        logic [7:0] exp [7];
        int         elen;
        int         lat;
`ifdef QUOT_ZERO_SUPPRESS_EN
        exp = '{8'h34, 8'h32, 8'h0D, 8'h0A, 8'h00, 8'h00, 8'h00}; elen = 4;
`else
        exp = '{8'h30, 8'h30, 8'h30, 8'h34, 8'h32, 8'h0D, 8'h0A}; elen = 7;
`endif
        bus.tx_ready = 1'b1;
        accept(16'd12345, lat);
        clear_cap();
        collect(5);
        total++; if (ncap !== 5) begin bad++; $display("FAIL midrst_digits: got %0d want 5", ncap); end
        total++; if (bus.tx_valid !== 1'b1 || bus.tx_data !== 8'h0D) begin bad++; $display("FAIL midrst_cr: got %b %h want 1 0d", bus.tx_valid, bus.tx_data); end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        total++; if (bus.tx_valid !== 1'b0) begin bad++; $display("FAIL midrst_tx_valid: got %b want 0", bus.tx_valid); end
        total++; if (bus.tx_data !== 8'h00) begin bad++; $display("FAIL midrst_tx_data: got %h want 00", bus.tx_data); end
        total++; if (bus.done !== 1'b0) begin bad++; $display("FAIL midrst_done: got %b want 0", bus.done); end
        @(negedge clk);
        total++; if (bus.in_ready !== 1'b1 || bus.tx_valid !== 1'b0) begin bad++; $display("FAIL midrst_recover: got rdy=%b vld=%b want 1 0", bus.in_ready, bus.tx_valid); end
        accept(16'd42, lat);
        total++; if (lat !== 17) begin bad++; $display("FAIL midrst_latency: got %0d want 17", lat); end
        clear_cap();
        collect(12);
        total++; if (ncap !== elen) begin bad++; $display("FAIL midrst_count: got %0d want %0d", ncap, elen); end
        for (int j = 0; j < elen; j++) begin
            total++;
            if (cap[j] !== exp[j]) begin bad++; $display("FAIL midrst_byte idx=%0d: got %h want %h", j, cap[j], exp[j]); end
        end
        total++; if (ndone !== 1) begin bad++; $display("FAIL midrst_done_pulse: got %0d want 1", ndone); end
    endtask

    initial begin
        rst          = 1'b1;
        bus.in_data  = '0;
        bus.in_valid = 1'b0;
        bus.tx_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        test_reset();
        test_digits();
        test_stall();
        test_ignore_busy();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

endmodule
